// File: rtl/dm_lsu_param.sv
// Parametrised data memory with an integrated load/store unit: byte-addressed
// requests, internal byte-lane build, extended loads, and a clear-after-reset sweep.
module dm_lsu_param #(
  parameter int AW             = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW+1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
  localparam state_t        ST_RESET = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_t          state_r, state_nxt_s;
  logic [AW-1:0]   clr_cnt_r;
  logic [31:0]     mem_r [0:(2**AW)-1];

  logic            clr_en_s;
  logic            ready_s;
  logic            accept_s;
  logic [1:0]      off_s;
  logic [AW-1:0]   widx_s;
  logic            err_s;
  logic [3:0]      be_s;
  logic [31:0]     wd_s;
  logic [31:0]     rd_word_s;
  logic [31:0]     sh_s;
  logic [31:0]     ld_s;

  logic            rsp_valid_r;
  logic [31:0]     rsp_rdata_r;
  logic            rsp_err_r;

  // Size 11 is never legal; halves need an even offset, words a zero offset.
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] off);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = off[0];
      2'b10:   e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: leave INIT once the last word has been cleared
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (clr_cnt_r == CNT_LAST) state_nxt_s = ST_RUN;
        else                       state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_RESET;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    clr_en_s = 1'b0;
    ready_s  = 1'b0;
    case (state_r)
      ST_INIT: clr_en_s = 1'b1;
      ST_RUN:  ready_s  = 1'b1;
      default: ready_s  = 1'b0;
    endcase
  end

  // Clear sweep pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_r <= {AW{1'b0}};
    end else if (clr_en_s) begin
      clr_cnt_r <= clr_cnt_r + CNT_ONE;
    end else begin
      clr_cnt_r <= clr_cnt_r;
    end
  end

  assign accept_s  = req_valid & ready_s;
  assign off_s     = req_addr[1:0];
  assign widx_s    = req_addr[AW+1:2];
  assign err_s     = size_err(req_size, off_s);
  assign rd_word_s = mem_r[widx_s];
  assign sh_s      = rd_word_s >> {off_s, 3'b000};

  // Store lane enables and lane-replicated write data
  always_comb begin
    be_s = 4'b0000;
    wd_s = 32'd0;
    case (req_size)
      2'b00: begin
        be_s = 4'b0001 << off_s;
        wd_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_s = 4'b0011 << off_s;
        wd_s = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be_s = 4'b1111;
        wd_s = req_wdata;
      end
      default: begin
        be_s = 4'b0000;
        wd_s = 32'd0;
      end
    endcase
    if (!(accept_s && req_we && !err_s)) be_s = 4'b0000;
    else                                 be_s = be_s;
  end

  // Load extraction and extension
  always_comb begin
    ld_s = 32'd0;
    case (req_size)
      2'b00:   ld_s = req_signed ? {{24{sh_s[7]}}, sh_s[7:0]} : {24'd0, sh_s[7:0]};
      2'b01:   ld_s = req_signed ? {{16{sh_s[15]}}, sh_s[15:0]} : {16'd0, sh_s[15:0]};
      2'b10:   ld_s = rd_word_s;
      default: ld_s = 32'd0;
    endcase
  end

  // Array write port; the reset branch holds the array untouched while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (clr_en_s) begin
      mem_r[clr_cnt_r] <= 32'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) mem_r[widx_s][8*k +: 8] <= wd_s[8*k +: 8];
      end
    end
  end

  // Registered response, one cycle after each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
    end else begin
      rsp_valid_r <= accept_s;
      rsp_err_r   <= accept_s & err_s;
      rsp_rdata_r <= (accept_s && !req_we && !err_s) ? ld_s : 32'd0;
    end
  end

  assign req_ready = ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dm_lsu_param.sv
// Bench for dm_lsu_param (AW=4): byte-array reference model checked every cycle,
// plus directed load/store vectors with hand-computed results.
module tb_dm_lsu_param;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW+1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int checks = 0;
  int errors = 0;

  dm_lsu_param #(.AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference model: memory as 64 bytes, ready after 16 clock edges out of reset
  logic [7:0]  m_mem [0:63];
  int          m_cnt;
  logic        m_valid;
  logic [31:0] m_rdata;
  logic        m_err;

  function automatic logic m_illegal(input logic [1:0] size, input int off);
    return (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
  endfunction

  function automatic int m_nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_rdata <= 32'd0;
      m_err   <= 1'b0;
    end else if (m_cnt < 16) begin
      for (int i = 0; i < 4; i++) m_mem[4*m_cnt + i] <= 8'd0;
      m_cnt   <= m_cnt + 1;
      m_valid <= 1'b0;
    end else begin
      m_valid <= req_valid;
      m_err   <= 1'b0;
      m_rdata <= 32'd0;
      if (req_valid) begin
        int base, off, n;
        logic [31:0] v, mask;
        base = int'(req_addr) & ~3;
        off  = int'(req_addr) % 4;
        n    = m_nbytes(req_size);
        if (m_illegal(req_size, off)) begin
          m_err <= 1'b1;
        end else if (req_we) begin
          for (int i = 0; i < n; i++) m_mem[base + off + i] <= req_wdata[8*i +: 8];
        end else begin
          v = 32'd0;
          for (int i = 0; i < n; i++) v = v | (32'(m_mem[base + off + i]) << (8*i));
          if (n < 4) begin
            mask = (32'd1 << (8*n)) - 32'd1;
            if (req_signed && v[8*n-1]) v = v | ~mask;
          end
          m_rdata <= v;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if (req_ready !== (rst_n === 1'b1 && m_cnt >= 16)) begin
      errors++;
      $display("FAIL ready: got %b want %b", req_ready, (m_cnt >= 16));
    end
    checks++;
    if (rsp_valid !== m_valid) begin
      errors++;
      $display("FAIL rsp_valid: got %b want %b", rsp_valid, m_valid);
    end
    if (m_valid) begin
      checks++;
      if (rsp_rdata !== m_rdata || rsp_err !== m_err) begin
        errors++;
        $display("FAIL rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, m_rdata, m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic set_req(input logic we, input logic [5:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_size = size; req_signed = sgn; req_wdata = wd;
  endtask

  // One request; checks the response against literal values
  task automatic xact(input string name, input logic we, input logic [5:0] addr,
                      input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    set_req(we, addr, size, sgn, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, "_rdata"}, rsp_rdata, exp_rd);
    chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      if (req_ready !== 1'b1) n++;
    end
    chk(name, n, 32'd16);
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 6'h0, 2'd0, 1'b0, 32'd0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd0);
    #1 rst_n = 1'b1;

    // 1: clear duration, then cleared word reads zero
    wait_ready("init_cycles");
    xact("ld_3c", 1'b0, 6'h3C, 2'd2, 1'b0, 32'd0, 32'h0000_0000, 1'b0);

    // 2: word store, byte merge, readback
    xact("st_w10", 1'b1, 6'h10, 2'd2, 1'b0, 32'h8899_AABB, 32'd0, 1'b0);
    xact("st_b12", 1'b1, 6'h12, 2'd0, 1'b0, 32'h0000_007F, 32'd0, 1'b0);
    xact("ld_w10", 1'b0, 6'h10, 2'd2, 1'b0, 32'd0, 32'h887F_AABB, 1'b0);

    // 3: extensions
    xact("ld_sb13", 1'b0, 6'h13, 2'd0, 1'b1, 32'd0, 32'hFFFF_FF88, 1'b0);
    xact("ld_ub13", 1'b0, 6'h13, 2'd0, 1'b0, 32'd0, 32'h0000_0088, 1'b0);
    xact("ld_sh12", 1'b0, 6'h12, 2'd1, 1'b1, 32'd0, 32'hFFFF_887F, 1'b0);
    xact("ld_uh10", 1'b0, 6'h10, 2'd1, 1'b0, 32'd0, 32'h0000_AABB, 1'b0);

    // 4: misaligned / illegal accesses leave the array alone
    xact("st_w11", 1'b1, 6'h11, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
    xact("ld_h13", 1'b0, 6'h13, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1);
    xact("sz3_10", 1'b1, 6'h10, 2'd3, 1'b0, 32'h1111_1111, 32'd0, 1'b1);
    xact("ld_w10b", 1'b0, 6'h10, 2'd2, 1'b0, 32'd0, 32'h887F_AABB, 1'b0);

    // 5: back-to-back store then load of the same word
    set_req(1'b1, 6'h20, 2'd2, 1'b0, 32'h1234_5678);
    @(posedge clk); #1;
    set_req(1'b0, 6'h20, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    chk("b2b_v1", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_d1", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_v2", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_d2", rsp_rdata, 32'h1234_5678);

    // 6: reset right after a load accept drops the response and re-clears
    set_req(1'b0, 6'h20, 2'd2, 1'b0, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_v", {31'd0, rsp_valid}, 32'd0);
    chk("rst_drop_d", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready("reinit_cycles");
    xact("ld_20_clr", 1'b0, 6'h20, 2'd2, 1'b0, 32'd0, 32'h0000_0000, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
